beta_mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer that shares one unified memory port between the fetch unit and the execute-stage load/store path. It runs the ready/valid memory protocol (wait-for-ready, then wait-for-valid) with a 4-state FSM. It arbitrates between the two requesters with anti-starvation priority. For load/store traffic it generates byte enables, store-data lane replication, misalignment errors and load-data extraction with sign or zero extension.

---
 rtl/beta_pkg.sv | 29 ++
 rtl/beta_mem_align.sv | 56 +++++
 rtl/beta_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_beta_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta memory arbiter slice.
package beta_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

  localparam logic MEM_LOAD_OP  = 1'b0;
  localparam logic MEM_STORE_OP = 1'b1;

  localparam int arb_fsm_bsize = 2;

  typedef enum logic [arb_fsm_bsize-1:0] {
    ARB_IDLE = 2'b00,
    ARB_WRDY = 2'b01,
    ARB_WVLD = 2'b10,
    ARB_RESP = 2'b11
  } arb_state_e;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/beta_mem_align.sv
// Combinational lane logic: byte enables, store replication, alignment check
// and load extraction with sign/zero extension.
module beta_mem_align
  import beta_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      off_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      MEM_SIZE_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_SIZE_HALF: begin
        be_o         = 4'b0011 << off_i;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = off_i[0];
      end
      MEM_SIZE_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = |off_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

  // The addressed byte/half is moved down to bit 0 before extension.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (size_i)
      MEM_SIZE_BYTE:
        rdata_o = unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                             : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF:
        rdata_o = unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                             : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default:
        rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// Shares one memory port between fetch and load/store with anti-starvation
// priority; runs the ready/valid sequence and formats LS data.
module beta_mem_arbiter
  import beta_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_op_i,
  input  logic [1:0]      ls_size_i,
  input  logic            ls_unsigned_i,
  input  logic [XLEN-1:0] ls_addr_i,
  input  logic [XLEN-1:0] ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [XLEN-1:0] ls_rdata_o,
  output logic            ls_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rdy_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  arb_state_e      state_q, state_d;
  logic            prio_fetch_q, prio_fetch_d;
  logic            owner_ls_q, owner_ls_d;
  mem_req_t        req_q, req_d;
  logic            mem_req_q, mem_req_d;
  logic [1:0]      ls_off_q, ls_off_d;
  logic [1:0]      ls_size_q, ls_size_d;
  logic            ls_unsigned_q, ls_unsigned_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic            ls_rvalid_q, ls_rvalid_d;
  logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
  logic            ls_err_q, ls_err_d;

  logic            ls_win, if_win;
  logic [1:0]      al_size, al_off;
  logic            al_unsigned;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;
  logic            al_misaligned;

  // In IDLE the aligner sees the live request; afterwards the captured fields.
  assign al_size     = (state_q == ARB_IDLE) ? ls_size_i     : ls_size_q;
  assign al_off      = (state_q == ARB_IDLE) ? ls_addr_i[1:0] : ls_off_q;
  assign al_unsigned = (state_q == ARB_IDLE) ? ls_unsigned_i : ls_unsigned_q;

  beta_mem_align u_align (
    .size_i       (al_size),
    .off_i        (al_off),
    .unsigned_i   (al_unsigned),
    .wdata_i      (ls_wdata_i),
    .rdata_i      (mem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_misaligned),
    .rdata_o      (al_rdata)
  );

  assign ls_win   = ls_req_i && !(if_req_i && prio_fetch_q);
  assign if_win   = if_req_i && !ls_win;
  assign ls_gnt_o = (state_q == ARB_IDLE) && ls_win;
  assign if_gnt_o = (state_q == ARB_IDLE) && if_win;

  always_comb begin
    state_d       = state_q;
    prio_fetch_d  = prio_fetch_q;
    owner_ls_d    = owner_ls_q;
    req_d         = req_q;
    mem_req_d     = mem_req_q;
    ls_off_d      = ls_off_q;
    ls_size_d     = ls_size_q;
    ls_unsigned_d = ls_unsigned_q;
    if_rvalid_d   = 1'b0;
    if_rdata_d    = if_rdata_q;
    ls_rvalid_d   = 1'b0;
    ls_rdata_d    = ls_rdata_q;
    ls_err_d      = ls_err_q;
    case (state_q)
      ARB_IDLE: begin
        if (ls_win) begin
          owner_ls_d    = 1'b1;
          prio_fetch_d  = if_req_i;
          ls_off_d      = ls_addr_i[1:0];
          ls_size_d     = ls_size_i;
          ls_unsigned_d = ls_unsigned_i;
          // Illegal accesses skip the memory and answer on the next cycle.
          if (al_misaligned) begin
            state_d     = ARB_RESP;
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b1;
            ls_rdata_d  = '0;
          end else begin
            state_d     = ARB_WRDY;
            mem_req_d   = 1'b1;
            req_d.we    = ls_op_i;
            req_d.be    = al_be;
            req_d.addr  = ls_addr_i & WORD_MASK;
            req_d.wdata = al_wdata;
          end
        end else if (if_win) begin
          owner_ls_d   = 1'b0;
          prio_fetch_d = 1'b0;
          state_d      = ARB_WRDY;
          mem_req_d    = 1'b1;
          req_d.we     = 1'b0;
          req_d.be     = 4'b1111;
          req_d.addr   = if_addr_i & WORD_MASK;
          req_d.wdata  = '0;
        end
      end
      ARB_WRDY: begin
        if (mem_rdy_i) begin
          mem_req_d = 1'b0;
          state_d   = ARB_WVLD;
        end
      end
      ARB_WVLD: begin
        if (mem_rvalid_i) begin
          state_d = ARB_RESP;
          if (owner_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b0;
            ls_rdata_d  = req_q.we ? '0 : al_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        ls_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      prio_fetch_q  <= 1'b0;
      owner_ls_q    <= 1'b0;
      req_q         <= '0;
      mem_req_q     <= 1'b0;
      ls_off_q      <= 2'b00;
      ls_size_q     <= 2'b00;
      ls_unsigned_q <= 1'b0;
      if_rvalid_q   <= 1'b0;
      if_rdata_q    <= '0;
      ls_rvalid_q   <= 1'b0;
      ls_rdata_q    <= '0;
      ls_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_fetch_q  <= prio_fetch_d;
      owner_ls_q    <= owner_ls_d;
      req_q         <= req_d;
      mem_req_q     <= mem_req_d;
      ls_off_q      <= ls_off_d;
      ls_size_q     <= ls_size_d;
      ls_unsigned_q <= ls_unsigned_d;
      if_rvalid_q   <= if_rvalid_d;
      if_rdata_q    <= if_rdata_d;
      ls_rvalid_q   <= ls_rvalid_d;
      ls_rdata_q    <= ls_rdata_d;
      ls_err_q      <= ls_err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = req_q.we;
  assign mem_be_o    = req_q.be;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Directed self-checking bench for beta_mem_arbiter.
module tb_beta_mem_arbiter;
  import beta_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_op_i, ls_unsigned_i;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rdy_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int testCount = 0;
  int failCount = 0;

  beta_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_gnt_o      (if_gnt_o),
    .if_rvalid_o   (if_rvalid_o),
    .if_rdata_o    (if_rdata_o),
    .ls_req_i      (ls_req_i),
    .ls_op_i       (ls_op_i),
    .ls_size_i     (ls_size_i),
    .ls_unsigned_i (ls_unsigned_i),
    .ls_addr_i     (ls_addr_i),
    .ls_wdata_i    (ls_wdata_i),
    .ls_gnt_o      (ls_gnt_o),
    .ls_rvalid_o   (ls_rvalid_o),
    .ls_rdata_o    (ls_rdata_o),
    .ls_err_o      (ls_err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdy_i     (mem_rdy_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One complete LS transaction; memory answers rdy after 'waits' cycles, then rvalid.
  task automatic applyStimulus(input string tag, input logic op, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int waits, input logic expErr,
                               input logic [31:0] expAddr, input logic [3:0] expBe,
                               input logic [31:0] expWdata, input logic [31:0] expRdata);
    @(negedge clk);
    ls_req_i = 1'b1; ls_op_i = op; ls_size_i = size; ls_unsigned_i = uns;
    ls_addr_i = addr; ls_wdata_i = wdata;
    #1 checkOutput({tag, ".gnt"}, 32'(ls_gnt_o), 32'd1);
    @(negedge clk);
    ls_req_i = 1'b0;
    #1;
    if (expErr) begin
      checkOutput({tag, ".rvalid"}, 32'(ls_rvalid_o), 32'd1);
      checkOutput({tag, ".err"}, 32'(ls_err_o), 32'd1);
      checkOutput({tag, ".rdata"}, ls_rdata_o, 32'd0);
      checkOutput({tag, ".noreq"}, 32'(mem_req_o), 32'd0);
      @(negedge clk);
      #1 checkOutput({tag, ".rvalid_end"}, 32'(ls_rvalid_o), 32'd0);
      checkOutput({tag, ".noreq2"}, 32'(mem_req_o), 32'd0);
    end else begin
      checkOutput({tag, ".req"}, 32'(mem_req_o), 32'd1);
      checkOutput({tag, ".addr"}, mem_addr_o, expAddr);
      checkOutput({tag, ".be"}, 32'(mem_be_o), 32'(expBe));
      checkOutput({tag, ".we"}, 32'(mem_we_o), 32'(op));
      if (op == MEM_STORE_OP) checkOutput({tag, ".wdata"}, mem_wdata_o, expWdata);
      for (int i = 0; i < waits; i++) begin
        mem_rdy_i = 1'b0;
        @(negedge clk);
        #1 checkOutput({tag, ".req_held"}, 32'(mem_req_o), 32'd1);
        checkOutput({tag, ".addr_held"}, mem_addr_o, expAddr);
      end
      mem_rdy_i = 1'b1;
      @(negedge clk);
      mem_rdy_i = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i = rdata;
      #1 checkOutput({tag, ".req_drop"}, 32'(mem_req_o), 32'd0);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1 checkOutput({tag, ".rvalid"}, 32'(ls_rvalid_o), 32'd1);
      checkOutput({tag, ".rdata"}, ls_rdata_o, expRdata);
      checkOutput({tag, ".err"}, 32'(ls_err_o), 32'd0);
      @(negedge clk);
      #1 checkOutput({tag, ".rvalid_end"}, 32'(ls_rvalid_o), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_op_i = 1'b0; ls_size_i = 2'b00; ls_unsigned_i = 1'b0;
    ls_addr_i = '0; ls_wdata_i = '0;
    mem_rdy_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("reset.mem_addr", mem_addr_o, 32'd0);
    checkOutput("reset.rvalid", 32'({if_rvalid_o, ls_rvalid_o, ls_err_o}), 32'd0);
    checkOutput("reset.state", 32'(dut.state_q), 32'(ARB_IDLE));
    rst = 1'b0;

    // Fetch only, zero-wait memory
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    #1 checkOutput("fetch.gnt", 32'(if_gnt_o), 32'd1);
    checkOutput("fetch.ls_gnt", 32'(ls_gnt_o), 32'd0);
    @(negedge clk);
    if_req_i = 1'b0; mem_rdy_i = 1'b1;
    #1 checkOutput("fetch.req", 32'(mem_req_o), 32'd1);
    checkOutput("fetch.addr", mem_addr_o, 32'h0000_0100);
    checkOutput("fetch.be", 32'(mem_be_o), 32'hF);
    checkOutput("fetch.we", 32'(mem_we_o), 32'd0);
    @(negedge clk);
    mem_rdy_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1 checkOutput("fetch.rvalid", 32'(if_rvalid_o), 32'd1);
    checkOutput("fetch.rdata", if_rdata_o, 32'hDEAD_BEEF);
    checkOutput("fetch.ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    @(negedge clk);
    #1 checkOutput("fetch.rvalid_end", 32'(if_rvalid_o), 32'd0);

    applyStimulus("lb", MEM_LOAD_OP, MEM_SIZE_BYTE, 1'b0, 32'h203, 32'h0, 32'h8011_2233, 0,
                  1'b0, 32'h200, 4'b1000, 32'h0, 32'hFFFF_FF80);
    applyStimulus("lbu", MEM_LOAD_OP, MEM_SIZE_BYTE, 1'b1, 32'h203, 32'h0, 32'h8011_2233, 0,
                  1'b0, 32'h200, 4'b1000, 32'h0, 32'h0000_0080);
    applyStimulus("lh", MEM_LOAD_OP, MEM_SIZE_HALF, 1'b0, 32'h202, 32'h0, 32'h8011_2233, 0,
                  1'b0, 32'h200, 4'b1100, 32'h0, 32'hFFFF_8011);
    applyStimulus("lhu", MEM_LOAD_OP, MEM_SIZE_HALF, 1'b1, 32'h202, 32'h0, 32'h8011_2233, 1,
                  1'b0, 32'h200, 4'b1100, 32'h0, 32'h0000_8011);
    applyStimulus("lbu1", MEM_LOAD_OP, MEM_SIZE_BYTE, 1'b1, 32'h201, 32'h0, 32'h8011_2233, 0,
                  1'b0, 32'h200, 4'b0010, 32'h0, 32'h0000_0022);
    applyStimulus("lw", MEM_LOAD_OP, MEM_SIZE_WORD, 1'b0, 32'h404, 32'h0, 32'hCAFE_F00D, 0,
                  1'b0, 32'h404, 4'b1111, 32'h0, 32'hCAFE_F00D);
    applyStimulus("sh", MEM_STORE_OP, MEM_SIZE_HALF, 1'b0, 32'h302, 32'h0000_ABCD, 32'h1234_5678, 3,
                  1'b0, 32'h300, 4'b1100, 32'hABCD_ABCD, 32'h0);
    applyStimulus("sb", MEM_STORE_OP, MEM_SIZE_BYTE, 1'b0, 32'h301, 32'h1122_3344, 32'h1234_5678, 0,
                  1'b0, 32'h300, 4'b0010, 32'h4444_4444, 32'h0);
    applyStimulus("lw_mis", MEM_LOAD_OP, MEM_SIZE_WORD, 1'b0, 32'h401, 32'h0, 32'h0, 0,
                  1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
    applyStimulus("sh_mis", MEM_STORE_OP, MEM_SIZE_HALF, 1'b0, 32'h303, 32'h0, 32'h0, 0,
                  1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
    applyStimulus("rsvd", MEM_LOAD_OP, 2'b11, 1'b0, 32'h400, 32'h0, 32'h0, 0,
                  1'b1, 32'h0, 4'b0, 32'h0, 32'h0);

    // Both requesters held: grants alternate LS, IF, LS, IF
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h500;
    ls_req_i = 1'b1; ls_op_i = MEM_LOAD_OP; ls_size_i = MEM_SIZE_WORD; ls_unsigned_i = 1'b0;
    ls_addr_i = 32'h600;
    for (int k = 0; k < 4; k++) begin
      #1 checkOutput("alt.if_gnt", 32'(if_gnt_o), (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("alt.ls_gnt", 32'(ls_gnt_o), (k % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      mem_rdy_i = 1'b1;
      #1 checkOutput("alt.addr", mem_addr_o, (k % 2 == 1) ? 32'h500 : 32'h600);
      checkOutput("alt.no_gnt", 32'({if_gnt_o, ls_gnt_o}), 32'd0);
      @(negedge clk);
      mem_rdy_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_1000 + 32'(k);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1 checkOutput("alt.if_rvalid", 32'(if_rvalid_o), (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("alt.ls_rvalid", 32'(ls_rvalid_o), (k % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;

    // Reset while waiting for rvalid; late rvalid must be dropped
    @(negedge clk);
    ls_req_i = 1'b1; ls_op_i = MEM_LOAD_OP; ls_size_i = MEM_SIZE_WORD; ls_addr_i = 32'h700;
    #1 checkOutput("rst.gnt", 32'(ls_gnt_o), 32'd1);
    @(negedge clk);
    ls_req_i = 1'b0; mem_rdy_i = 1'b1;
    @(negedge clk);
    mem_rdy_i = 1'b0;
    #1 checkOutput("rst.in_wvld", 32'(dut.state_q), 32'(ARB_WVLD));
    rst = 1'b1;
    #1 checkOutput("rst.state", 32'(dut.state_q), 32'(ARB_IDLE));
    checkOutput("rst.mem_out", mem_addr_o | 32'({mem_req_o, mem_we_o, mem_be_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1 checkOutput("rst.no_rvalid", 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);
    checkOutput("rst.idle", 32'(dut.state_q), 32'(ARB_IDLE));
    @(negedge clk);
    #1 checkOutput("rst.no_rvalid2", 32'({if_rvalid_o, ls_rvalid_o}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
